// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan display.
//   NUM_DIGITS : number of multiplexed digits on the board
//   DIG_W      : width of the digit index
//   SEG_OFF    : active-low "all segments off" pattern
//   HEX_SEG    : hex nibble to active-low {a,b,c,d,e,f,g} segment table
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned DIG_W      = 3;
  localparam logic [6:0]  SEG_OFF    = 7'h7F;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment decoder.
//   nibble : 4-bit hex value
//   seg    : segments {a,b,c,d,e,f,g}, active-low
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = HEX_SEG[nibble];
  end

endmodule

// File: rtl/seg7_scan_display.sv
// Eight-digit multiplexed seven-segment driver. Latches a 32-bit word and
// scans its hex digits onto shared segment/anode pins, with optional
// leading-zero blanking and a global blank control.
//   Clk      : system clock
//   Rst      : synchronous active-high reset
//   DataIn   : word to display, nibble i on digit i (digit 0 rightmost)
//   Load     : capture DataIn into the display register
//   Blank    : turn all digits off while scanning continues
//   out7     : segments {a,b,c,d,e,f,g}, active-low, registered
//   en_out   : digit anodes, active-low, registered
//   ScanTick : one-cycle pulse when the digit index advances
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned CNT_W       = 17,
  parameter int unsigned BLANK_LZ    = 1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] DataIn,
  input  logic        Load,
  input  logic        Blank,
  output logic [6:0]  out7,
  output logic [7:0]  en_out,
  output logic        ScanTick
);

  logic [31:0]           data_reg;
  logic [CNT_W-1:0]      cnt;
  logic [DIG_W-1:0]      dig;
  logic                  terminal;
  logic [3:0]            nibble;
  logic [6:0]            seg_dec;
  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  digit_on;

  assign terminal = (cnt == CNT_W'(REFRESH_DIV - 1));

  // Digit i (i > 0) is a leading zero when every nibble from i upward is 0.
  always_comb begin
    lz_mask = '0;
    for (int unsigned i = 1; i < NUM_DIGITS; i++) begin
      lz_mask[i] = ((data_reg >> (4 * i)) == '0);
    end
  end

  always_comb begin
    nibble   = data_reg[{dig, 2'b00} +: 4];
    digit_on = !Blank && !((BLANK_LZ != 0) && lz_mask[dig]);
  end

  hex_to_seg7 u_dec (
    .nibble (nibble),
    .seg    (seg_dec)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      data_reg <= '0;
    end else if (Load) begin
      data_reg <= DataIn;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt      <= '0;
      dig      <= '0;
      ScanTick <= 1'b0;
    end else if (terminal) begin
      cnt      <= '0;
      dig      <= dig + DIG_W'(1);
      ScanTick <= 1'b1;
    end else begin
      cnt      <= cnt + CNT_W'(1);
      ScanTick <= 1'b0;
    end
  end

  // Outputs are decoded from the pre-edge digit index and data register, so a
  // Load coinciding with a digit advance never mixes old and new nibbles.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      out7   <= SEG_OFF;
      en_out <= '1;
    end else if (digit_on) begin
      out7   <= seg_dec;
      en_out <= ~(NUM_DIGITS'(1) << dig);
    end else begin
      out7   <= SEG_OFF;
      en_out <= '1;
    end
  end

endmodule

// File: tb/tb_seg7_scan_display.sv
module tb_seg7_scan_display;

  localparam int unsigned RDIV = 4;

  localparam logic [6:0] TB_SEG [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };

  typedef struct {
    logic [6:0] seg;
    logic [7:0] en;
    logic       tick;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [31:0] DataIn = '0;
  logic        Load = 1'b0;
  logic        Blank = 1'b0;
  logic [6:0]  out7;
  logic [7:0]  en_out;
  logic        ScanTick;

  exp_t        q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model state: displayed word and clock edges since reset.
  logic [31:0] m_data = '0;
  int unsigned m_edges = 0;

  always #5 Clk = ~Clk;

  seg7_scan_display #(
    .REFRESH_DIV (RDIV),
    .CNT_W       (3),
    .BLANK_LZ    (1)
  ) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .DataIn   (DataIn),
    .Load     (Load),
    .Blank    (Blank),
    .out7     (out7),
    .en_out   (en_out),
    .ScanTick (ScanTick)
  );

  function automatic int unsigned m_digit();
    return (m_edges / RDIV) % 8;
  endfunction

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  task automatic cycle(input logic rst, input logic ld, input logic [31:0] din,
                       input logic blk);
    exp_t        e;
    int unsigned d;
    logic [31:0] upper;
    @(negedge Clk);
    Rst = rst; Load = ld; DataIn = din; Blank = blk;
    if (rst) begin
      e.seg = 7'h7F; e.en = 8'hFF; e.tick = 1'b0;
      m_data = '0;
      m_edges = 0;
    end else begin
      d = m_digit();
      upper = m_data >> (4 * d);
      e.tick = ((m_edges % RDIV) == RDIV - 1);
      if (!blk && (d == 0 || upper != 0)) begin
        e.seg = TB_SEG[upper[3:0]];
        e.en  = 8'hFF ^ (8'd1 << d);
      end else begin
        e.seg = 7'h7F;
        e.en  = 8'hFF;
      end
      if (ld) m_data = din;
      m_edges++;
    end
    q.push_back(e);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) cycle(1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  // Monitor: compare every registered output sample against the queue.
  always @(posedge Clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (out7 !== e.seg) begin
        errors++;
        $display("FAIL out7 @%0t: got %h expected %h", $time, out7, e.seg);
      end
      checks++;
      if (en_out !== e.en) begin
        errors++;
        $display("FAIL en_out @%0t: got %h expected %h", $time, en_out, e.en);
      end
      checks++;
      if (ScanTick !== e.tick) begin
        errors++;
        $display("FAIL ScanTick @%0t: got %b expected %b", $time, ScanTick, e.tick);
      end
    end
  end

  initial begin
    int unsigned guard;
    logic [31:0] r;

    // Reset for 3 cycles, then full value scan.
    repeat (3) cycle(1'b1, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b1, 32'h1234ABCD, 1'b0);
    idle(40);

    // Leading zeros.
    cycle(1'b0, 1'b1, 32'h000000A5, 1'b0);
    idle(40);
    cycle(1'b0, 1'b1, 32'h00000000, 1'b0);
    idle(40);

    // Blank mid-scan for 10 cycles.
    cycle(1'b0, 1'b1, 32'h89ABCDEF, 1'b0);
    idle(5);
    repeat (10) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    idle(20);

    // Load coinciding with the terminal count.
    guard = 0;
    while ((m_edges % RDIV) != RDIV - 1 && guard < 8) begin
      idle(1);
      guard++;
    end
    cycle(1'b0, 1'b1, 32'hFFFFFFFF, 1'b0);
    idle(40);

    // Reset pulse while digit 5 is showing.
    cycle(1'b0, 1'b1, 32'h87654321, 1'b0);
    guard = 0;
    while (m_digit() != 5 && guard < 64) begin
      idle(1);
      guard++;
    end
    cycle(1'b1, 1'b1, 32'hDEADBEEF, 1'b1);
    idle(40);

    // Randomized traffic.
    for (int unsigned k = 0; k < 400; k++) begin
      r = $urandom >> $urandom_range(0, 31);
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) == 0), r,
            ($urandom_range(0, 9) == 0));
    end
    idle(4);

    repeat (2) @(posedge Clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_display.md
Name: seg7_scan_display

Overview:
- Sits directly downstream of the pipelined CPU top; drives the board's 8-digit seven-segment display.
- Latches a 32-bit word presented by the CPU, for example a write-back result or a debug register.
- Time-multiplexes the eight hex digits onto the shared out7 and en_out pins.
- Provides a refresh counter, digit scanning, leading-zero blanking and a per-digit scan tick.

Parameters:
REFRESH_DIV, 100000, Clk cycles each digit stays enabled (1 kHz per digit at 100 MHz); minimum 2.
CNT_W, 17, width of the refresh counter; must satisfy 2^CNT_W >= REFRESH_DIV.
BLANK_LZ, 1, 1 enables leading-zero blanking, 0 always shows all 8 digits.

Ports:
Clk  input  1  system clock; the block uses this single clock only.
Rst  input  1  synchronous, active-high reset.
DataIn  input  32  word to display; nibble i maps to digit i (digit 0 is rightmost).
Load  input  1  when 1 on a Clk edge, DataIn is captured into the display register.
Blank  input  1  when 1, all digits are off; scanning continues.
out7  output  7  segments {a,b,c,d,e,f,g} = out7[6:0], active-low.
en_out  output  8  digit anodes, active-low, one-hot-low when displaying.
ScanTick  output  1  one-cycle pulse when the digit index advances.

Behaviour:
- Reset, sampled synchronously:
  - DataReg = 0, refresh counter = 0, digit index = 0.
  - out7 = 7'h7F, en_out = 8'hFF, ScanTick = 0.
  - Reset asserted mid-scan overrides Load and Blank in that cycle.
- Data register:
  - Load = 1 captures DataIn at the edge.
  - Without Load, DataReg holds indefinitely.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - At the terminal count, ScanTick = 1 for exactly one cycle (registered, same edge as the wrap).
  - At that same edge, the digit index increments mod 8; 7 wraps to 0.
- Outputs are registered with one cycle of latency:
  - out7 and en_out at cycle n+1 reflect the digit index, DataReg, Blank and blanking mask at cycle n.
- Digit i, enabled:
  - en_out = ~(8'b1 << i).
  - out7 = hex decode of DataReg[4i+3:4i].
- Hex decode, active-low: 0=01, 1=4F, 2=12, 3=06, 4=4C, 5=24, 6=20, 7=0F, 8=00, 9=04, A=08, b=60, C=31, d=42, E=30, F=38 (hex values of out7).
- Leading-zero blanking (BLANK_LZ = 1):
  - Digit i > 0 is blanked when DataReg[31:4i] == 0.
  - Digit 0 is never blanked, so a value of 0 shows a single "0".
  - A blanked digit drives en_out = 8'hFF and out7 = 7'h7F.
- Blank = 1: the next output cycle is en_out = 8'hFF and out7 = 7'h7F. The counter and digit index keep running, so there is no phase loss.
- Simultaneous Load and terminal count:
  - The new DataReg is used starting with the output cycle after the capture.
  - No digit ever shows a mixture of old and new nibbles.
- Outputs must never be glitch-combinational; every output comes from a flip-flop.

Decomposition:
- Shared package seg7_pkg holds:
  - NUM_DIGITS = 8.
  - SEG_OFF = 7'h7F.
  - The 16-entry hex-to-segment constant table.
  - The digit-index width (3).
- One natural sub-module, hex_to_seg7: purely combinational 4-bit to 7-bit active-low decoder using the package table, instantiated once on the muxed nibble.
- Refresh counter, digit index, blanking mask and output registers all live in seg7_scan_display.

Test Plan:
- Sim setup for all scenarios: REFRESH_DIV = 4.
- Reset: Rst = 1 for 3 cycles, then 0 -> during reset out7 = 7F, en_out = FF, ScanTick = 0. The first ScanTick occurs exactly 4 cycles after Rst deasserts.
- Full value: Load DataIn = 32'h1234ABCD, BLANK_LZ = 1 -> over 32 cycles en_out steps FE, FD, FB, ..., 7F. out7 sequence is 42 (d), 31 (C), 60 (b), 08 (A), 4C (4), 06 (3), 12 (2), 4F (1). ScanTick fires every 4 cycles.
- Leading zeros: Load 32'h000000A5 -> digits 0 and 1 show 24 and 08; digits 2..7 give en_out = FF. Load 0 -> only digit 0 is enabled, showing 01.
- Blank: assert Blank for 10 cycles mid-scan -> en_out = FF one cycle after assertion and throughout. On release, scanning resumes at the digit index implied by continuous counting, not reset to 0.
- Load/tick collision: assert Load with DataIn = 32'hFFFFFFFF on the cycle the counter is at 3 -> the next enabled digit shows 38. No cycle shows an old nibble after the collision edge.
- Mid-scan reset: pulse Rst for 1 cycle while on digit 5 with DataReg nonzero -> next cycle out7 = 7F and en_out = FF. DataReg = 0, so thereafter only digit 0 shows 01.
